alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle controller that accepts one ALU command at a time over a valid/ready handshake, selects operands, and sequences the 16-bit ALU operations. Single-cycle logic, shift and add operations complete in one execute cycle. Multiply uses a fixed-latency wait, and divide uses an iterative restoring divider. Results return over a valid/ready response channel and update an internal accumulator, which can be fed back as operand B, matching the accumulator-feedback path of the input-register stage.

## Interface
- WIDTH, 16: datapath width. Only 16 is supported.
- MUL_LAT, 2: extra wait cycles for MUL (1..7).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  4  opcode: see Operation
- cmd_bsel  in  2  operand B source: 0 = cmd_b, 1 = accumulator, 2 = zero, 3 = hold previous B
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B; [4:0] is the shift amount for shifts
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_data  out  WIDTH  result
- rsp_carry  out  1  carry-out (ADD only, else 0)
- rsp_err  out  1  illegal opcode or divide-by-zero
- acc  out  WIDTH  accumulator value
- busy  out  1  state is not IDLE

## Operation
- Opcodes:
  - 0 ADD: A+B, carry-in 0
  - 1 AND
  - 2 NAND
  - 3 OR
  - 4 NOR
  - 5 XOR
  - 6 XNOR
  - 7 SHL: A<<B[4:0]
  - 8 SHR: logical A>>B[4:0]
  - 9 MUL: low 16 bits of A*B
  - 10 DIV: unsigned quotient A/B
  - 11 CLRACC: result 0, acc := 0
  - 12..15: illegal
- Shift amounts of 16..31 give 0.
- States: IDLE, EXEC, MULW, DIVI, RESP.
- IDLE: when cmd_valid && cmd_ready, capture the opcode, A, and B (per cmd_bsel) at the same edge.
  - Go to EXEC, or to MULW for MUL, or to DIVI for DIV.
  - bsel=3 keeps the B register unchanged.
- EXEC: compute and register the result, then go to RESP.
- MULW: count down MUL_LAT cycles, register the product, then go to RESP.
- DIVI: run 16 restoring iterations, one per cycle, then go to RESP.
  - B=0: skip the iterations; go to RESP next edge with rsp_data=16'hFFFF and rsp_err=1.
- RESP: hold rsp_valid and the data stable until rsp_ready. At the handshake edge go to IDLE.
- Accumulator update rules:
  - acc := rsp_data on entry to RESP, unless rsp_err=1.
  - Illegal opcodes follow the EXEC path with rsp_data=0, rsp_err=1, and acc unchanged.
- Operand ordering: bsel=1 with a back-to-back command sees the acc value written by the previous command.
- cmd_valid while busy is ignored, and no command is captured.

## Timing
- Reset (async assert, sync release): state=IDLE; acc, operand registers, rsp_data, rsp_carry, rsp_err = 0; rsp_valid=0, busy=0, cmd_ready=1.
- Reset asserted mid-operation aborts the operation immediately. No response is produced.
- Latency (accept edge to rsp_valid high):
  - EXEC ops: 2 edges.
  - MUL: 2+MUL_LAT edges.
  - DIV: 18 edges.
  - DIV by zero: 2 edges.
- rsp_ready high while the response is still pending has no effect.
- rsp_ready high on the first cycle of rsp_valid completes the response in 1 cycle.
- Throughput: the next command can be accepted the cycle after the response handshake. There is no overlap.
- cmd_ready is combinational from the state only, never from cmd_valid.

## Configuration
- ALU_SEQ_DIV_EN:
  - Defined: DIV is implemented as above.
  - Undefined: the divider is not instantiated, and opcode 10 is treated as illegal (EXEC path, rsp_data=0, rsp_err=1, latency 2).

## Structure
- Package alu_seq_pkg holds:
  - the opcode localparams (OP_ADD..OP_CLRACC);
  - the B-select encodings;
  - the state encoding;
  - DIV_ITERS=16.
- One sub-module, alu_seq_div:
  - iterative restoring divider with start/done;
  - quotient and remainder registers;
  - a 5-bit iteration counter.
- The FSM, operand registers, and single-cycle ops stay in alu_sequencer.

## Test plan
- Reset then ADD A=16'hFFFF, B=1, bsel=0 → rsp_data=0, rsp_carry=1, acc=0, rsp_valid 2 edges after accept.
- XOR A=16'h00FF, B=16'h0F0F; then SHR A=16'h00FF, bsel=3, with B set to 7 via a prior command → 16'h0FF0, then 16'h0001.
- MUL A=300, B=300, MUL_LAT=2 → rsp_data=16'h5F90, latency 4; then ADD A=1, bsel=1 → 16'h5F91.
- DIV A=1000, B=7 → 142, latency 18; DIV B=0 → 16'hFFFF, rsp_err=1, acc unchanged. Repeat without ALU_SEQ_DIV_EN → opcode 10 gives rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles → data stable, cmd_ready=0, and a cmd_valid pulse is ignored. Opcode 14 → rsp_err=1.
- Assert rst_n mid-DIV (iteration 8) → rsp_valid never rises, acc=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_sequencer shared definitions: opcodes, B-select codes, FSM states.
// Optional divider is enabled by defining ALU_SEQ_DIV_EN.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_AND    = 4'd1;
  localparam logic [3:0] OP_NAND   = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_NOR    = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_XNOR   = 4'd6;
  localparam logic [3:0] OP_SHL    = 4'd7;
  localparam logic [3:0] OP_SHR    = 4'd8;
  localparam logic [3:0] OP_MUL    = 4'd9;
  localparam logic [3:0] OP_DIV    = 4'd10;
  localparam logic [3:0] OP_CLRACC = 4'd11;

  localparam logic [1:0] BSEL_CMD  = 2'd0;
  localparam logic [1:0] BSEL_ACC  = 2'd1;
  localparam logic [1:0] BSEL_ZERO = 2'd2;
  localparam logic [1:0] BSEL_HOLD = 2'd3;

  localparam int DIV_ITERS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MULW,
    S_DIVI,
    S_RESP
  } state_t;

  // Shift amounts 16..31 flush the operand to zero.
  function automatic logic [15:0] shl16(
    input logic [15:0] a,
    input logic [4:0]  amt
  );
    return amt[4] ? 16'h0000 : (a << amt[3:0]);
  endfunction

  function automatic logic [15:0] shr16(
    input logic [15:0] a,
    input logic [4:0]  amt
  );
    return amt[4] ? 16'h0000 : (a >> amt[3:0]);
  endfunction

endpackage

// File: rtl/alu_seq_div.sv
// Iterative restoring divider: loads on start, one quotient bit per cycle.
// Only instantiated when ALU_SEQ_DIV_EN is defined.
module alu_seq_div
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [4:0]       cnt_q;
  logic             run_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // rem < divisor holds throughout, so a clear top bit of diff means no borrow.
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs_q};

  assign done     = run_q && (cnt_q == 5'd0);
  assign quotient = quo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= 5'(DIV_ITERS);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q != 5'd0) begin
        cnt_q <= cnt_q - 5'd1;
        if (!diff[WIDTH]) begin
          rem_q <= diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle 16-bit ALU command sequencer with accumulator feedback.
// Define ALU_SEQ_DIV_EN to build the iterative divider for opcode 10.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [1:0]       cmd_bsel,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  state_t state_q, state_d;

  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [2:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] ex_data;
  logic             ex_carry;
  logic             ex_err;
  logic [WIDTH-1:0] prod;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;
  assign rsp_err   = err_q;
  assign acc       = acc_q;

  // acc is already final when the next command is accepted.
  always_comb begin
    b_in = b_q;
    unique case (1'b1)
      cmd_bsel == BSEL_CMD:  b_in = cmd_b;
      cmd_bsel == BSEL_ACC:  b_in = acc_q;
      cmd_bsel == BSEL_ZERO: b_in = '0;
      cmd_bsel == BSEL_HOLD: b_in = b_q;
    endcase
  end

  assign prod = a_q * b_q;

  always_comb begin
    ex_data  = '0;
    ex_carry = 1'b0;
    ex_err   = 1'b0;
    case (op_q)
      OP_ADD:    {ex_carry, ex_data} = {1'b0, a_q} + {1'b0, b_q};
      OP_AND:    ex_data = a_q & b_q;
      OP_NAND:   ex_data = ~(a_q & b_q);
      OP_OR:     ex_data = a_q | b_q;
      OP_NOR:    ex_data = ~(a_q | b_q);
      OP_XOR:    ex_data = a_q ^ b_q;
      OP_XNOR:   ex_data = ~(a_q ^ b_q);
      OP_SHL:    ex_data = shl16(a_q, b_q[4:0]);
      OP_SHR:    ex_data = shr16(a_q, b_q[4:0]);
      OP_CLRACC: ex_data = '0;
      default:   ex_err  = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;

  assign div_start = (state_q == S_IDLE) && cmd_valid &&
                     (cmd_op == OP_DIV) && (b_in != '0);

  alu_seq_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (cmd_a),
    .divisor  (b_in),
    .done     (div_done),
    .quotient (div_quo)
  );
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    data_d  = data_q;
    carry_d = carry_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          a_d   = cmd_a;
          b_d   = b_in;
          cnt_d = 3'(MUL_LAT);
          if (cmd_op == OP_MUL) begin
            state_d = S_MULW;
`ifdef ALU_SEQ_DIV_EN
          end else if (cmd_op == OP_DIV) begin
            state_d = S_DIVI;
`endif
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        data_d  = ex_data;
        carry_d = ex_carry;
        err_d   = ex_err;
        if (!ex_err) acc_d = ex_data;
        state_d = S_RESP;
      end
      S_MULW: begin
        if (cnt_q == 3'd0) begin
          data_d  = prod;
          carry_d = 1'b0;
          err_d   = 1'b0;
          acc_d   = prod;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DIVI: begin
`ifdef ALU_SEQ_DIV_EN
        if (b_q == '0) begin
          data_d  = '1;
          carry_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (div_done) begin
          data_d  = div_quo;
          carry_d = 1'b0;
          err_d   = 1'b0;
          acc_d   = div_quo;
          state_d = S_RESP;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer; covers the ALU_SEQ_DIV_EN build
// when that macro is defined, otherwise the illegal-opcode-10 build.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [1:0]  cmd_bsel = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_err;
  logic [15:0] acc;
  logic        busy;

  alu_sequencer #(
    .WIDTH   (16),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_bsel  (cmd_bsel),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err),
    .acc       (acc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic        err;
    logic [15:0] acc;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_acc = '0;
  logic [15:0] m_b = '0;

  // Called at a negedge with the DUT idle; returns at the negedge after accept.
  task automatic issue(input logic [3:0] op, input logic [1:0] bsel,
                       input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [15:0] bv;
    logic [4:0]  sh;
    logic [31:0] p;
    bv = (bsel == 2'd0) ? b : (bsel == 2'd1) ? m_acc :
         (bsel == 2'd2) ? 16'h0000 : m_b;
    m_b = bv;
    sh = bv[4:0];
    p = 32'(a) * 32'(bv);
    e.data = '0;
    e.carry = 1'b0;
    e.err = 1'b0;
    e.lat = 2;
    case (op)
      4'd0: {e.carry, e.data} = 17'(a) + 17'(bv);
      4'd1: e.data = a & bv;
      4'd2: e.data = ~(a & bv);
      4'd3: e.data = a | bv;
      4'd4: e.data = ~(a | bv);
      4'd5: e.data = a ^ bv;
      4'd6: e.data = ~(a ^ bv);
      4'd7: e.data = (sh >= 5'd16) ? 16'h0 : 16'(32'(a) << sh);
      4'd8: e.data = (sh >= 5'd16) ? 16'h0 : 16'(a >> sh);
      4'd9: begin e.data = p[15:0]; e.lat = 2 + MUL_LAT; end
`ifdef ALU_SEQ_DIV_EN
      4'd10: begin
        if (bv == 16'h0) begin e.data = 16'hFFFF; e.err = 1'b1; end
        else begin e.data = a / bv; e.lat = 18; end
      end
`endif
      4'd11: e.data = 16'h0;
      default: e.err = 1'b1;
    endcase
    if (!e.err) m_acc = e.data;
    e.acc = m_acc;
    sbq.push_back(e);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_before_issue: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_bsel = bsel;
    cmd_a = a;
    cmd_b = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Scoreboard consumer: waits for rsp_valid, compares, optionally stalls.
  task automatic check_rsp(input string tag, input int hold);
    exp_t e;
    int   lat;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sbq.pop_front();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: rsp_valid %b after %0d edges", tag, rsp_valid, lat);
      return;
    end
    checks++;
    if (rsp_data !== e.data) begin
      errors++;
      $display("FAIL %s data: got %h want %h", tag, rsp_data, e.data);
    end
    checks++;
    if (rsp_carry !== e.carry || rsp_err !== e.err) begin
      errors++;
      $display("FAIL %s flags: got c=%b e=%b want c=%b e=%b",
               tag, rsp_carry, rsp_err, e.carry, e.err);
    end
    checks++;
    if (acc !== e.acc) begin
      errors++;
      $display("FAIL %s acc: got %h want %h", tag, acc, e.acc);
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, e.lat);
    end
    for (int i = 0; i < hold; i++) begin
      cmd_valid = (i == 1);
      cmd_op = OP_ADD;
      cmd_bsel = BSEL_CMD;
      cmd_a = 16'h1234;
      cmd_b = 16'h4321;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data ||
          cmd_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s stall%0d: got v=%b d=%h rdy=%b busy=%b want v=1 d=%h rdy=0 busy=1",
                 tag, i, rsp_valid, rsp_data, cmd_ready, busy, e.data);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: got v=%b rdy=%b want v=0 rdy=1",
               tag, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
        acc !== 16'h0 || rsp_data !== 16'h0 || rsp_err !== 1'b0 ||
        rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b busy=%b v=%b acc=%h d=%h e=%b c=%b",
               cmd_ready, busy, rsp_valid, acc, rsp_data, rsp_err, rsp_carry);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    issue(OP_ADD, BSEL_CMD, 16'hFFFF, 16'h0001);
    check_rsp("add_carry", 0);
    issue(OP_ADD, BSEL_CMD, 16'h1200, 16'h0034);
    check_rsp("add_plain", 0);
  endtask

  task automatic test_logic_shift();
    issue(OP_XOR, BSEL_CMD, 16'h00FF, 16'h0F0F);
    check_rsp("xor", 0);
    issue(OP_AND, BSEL_CMD, 16'hFFFF, 16'h0007);
    check_rsp("and_setb", 0);
    issue(OP_SHR, BSEL_HOLD, 16'h00FF, 16'hAAAA);
    check_rsp("shr_hold", 0);
    issue(OP_SHL, BSEL_CMD, 16'h0001, 16'd15);
    check_rsp("shl_15", 0);
    issue(OP_SHL, BSEL_CMD, 16'hFFFF, 16'd16);
    check_rsp("shl_16", 0);
    issue(OP_SHR, BSEL_CMD, 16'hFFFF, 16'd31);
    check_rsp("shr_31", 0);
    issue(OP_SHR, BSEL_CMD, 16'h8000, 16'hFFEF);
    check_rsp("shr_amt_lowbits", 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom));
      check_rsp("random", 0);
    end
  endtask

  task automatic test_mul();
    issue(OP_MUL, BSEL_CMD, 16'd300, 16'd300);
    check_rsp("mul", 0);
    issue(OP_ADD, BSEL_ACC, 16'd1, 16'h7777);
    check_rsp("add_accfb", 0);
  endtask

  task automatic test_div();
    issue(OP_CLRACC, BSEL_ZERO, 16'h5555, 16'h0);
    check_rsp("clracc", 0);
    issue(OP_ADD, BSEL_ZERO, 16'h0042, 16'h9999);
    check_rsp("add_bzero", 0);
    issue(OP_DIV, BSEL_CMD, 16'd1000, 16'd7);
    check_rsp("div", 0);
    issue(OP_DIV, BSEL_CMD, 16'hFFFF, 16'h0001);
    check_rsp("div_by_1", 0);
    issue(OP_DIV, BSEL_CMD, 16'd1234, 16'd0);
    check_rsp("div_zero", 0);
  endtask

  task automatic test_backpressure();
    issue(OP_ADD, BSEL_CMD, 16'h1111, 16'h2222);
    check_rsp("stall", 5);
    issue(OP_ADD, BSEL_HOLD, 16'h0001, 16'h0000);
    check_rsp("after_ignored", 0);
    issue(4'd14, BSEL_CMD, 16'h1234, 16'h5678);
    check_rsp("illegal14", 0);
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    issue(OP_OR, BSEL_CMD, 16'h0F00, 16'h00F0);
    rsp_ready = 1'b1;
    check_rsp("b2b_first", 0);
    rsp_ready = 1'b1;
    issue(OP_ADD, BSEL_ACC, 16'h0001, 16'h0000);
    rsp_ready = 1'b1;
    check_rsp("b2b_accfb", 0);
    rsp_ready = 1'b1;
    issue(OP_XNOR, BSEL_ACC, 16'h0FF1, 16'h0000);
    check_rsp("b2b_xnor", 0);
  endtask

  task automatic test_reset_mid_op();
    bit seen;
`ifdef ALU_SEQ_DIV_EN
    issue(OP_DIV, BSEL_CMD, 16'd1000, 16'd7);
    repeat (8) @(negedge clk);
`else
    issue(OP_MUL, BSEL_CMD, 16'd3, 16'd5);
    @(negedge clk);
`endif
    checks++;
    if (busy !== 1'b1 || acc === 16'h0) begin
      errors++;
      $display("FAIL midop_pre: got busy=%b acc=%h want busy=1 acc!=0", busy, acc);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || acc !== 16'h0) begin
      errors++;
      $display("FAIL midop_async: got v=%b rdy=%b acc=%h want 0 1 0",
               rsp_valid, cmd_ready, acc);
    end
    sbq.delete();
    m_acc = '0;
    m_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || acc !== 16'h0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_after: got seen=%b acc=%h rdy=%b busy=%b want 0 0 1 0",
               seen, acc, cmd_ready, busy);
    end
    issue(OP_ADD, BSEL_HOLD, 16'h0005, 16'hFFFF);
    check_rsp("post_reset_hold", 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic_shift();
    test_mul();
    test_div();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
